stack_row_engine: RTL and testbench
===================================

# stack_row_engine

Moving-row engine for the block-stacker game. Sits directly downstream of the level controller: it consumes the per-level `speed_count` and `num_blocks`, sweeps the active row left/right across the playfield at that speed, and latches the row on a player drop. It then judges overlap against the row below, and returns `next_signal` (success) or `fail` to the level controller and the game top.

## Interface
Parameters:
- `COLS`, 10: playfield width in columns; legal range 2..15.
- `POSW`, 4: column index width; must satisfy 2^POSW > COLS.

Ports:
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `frame_tick`, input, 1: one-cycle pulse per display frame (60 Hz).
- `start`, input, 1: one-cycle pulse; arms a new row (same pulse as the level controller's `go`).
- `drop`, input, 1: one-cycle pulse from the debounced player button.
- `speed_count`, input, 11: frames per one-column step.
- `num_blocks`, input, 4: maximum row width for this level.
- `curr_level`, input, 6: current level, 1..15; 1 means bottom row.
- `row_mask`, output, COLS: occupied columns of the moving row; bit 0 is leftmost.
- `row_pos`, output, POSW: column index of the row's leftmost block.
- `base_mask`, output, COLS: occupied columns of the last successfully placed row.
- `next_signal`, output, 1: one-cycle pulse; the placement overlapped.
- `fail`, output, 1: one-cycle pulse; the placement missed completely.
- `busy`, output, 1: high in MOVE and JUDGE.

## Operation
- States: IDLE, MOVE, JUDGE, REPORT.
- IDLE: `busy`=0. On `start`:
  - width W = min(`num_blocks`, cur_w, COLS). W is forced to ≥1.
  - cur_w is the width register, reset to COLS. If `curr_level`==1, cur_w is treated as COLS and `base_mask` is treated as all ones.
  - Load `row_pos`=0, `row_mask`=(2^W−1), dir=right, frame counter fc=0.
  - Go to MOVE.
- MOVE:
  - Each `frame_tick` increments fc.
  - When fc reaches max(`speed_count`,1)−1 on a tick, fc clears and the row steps one column in dir.
  - Bounce: if the rightmost block is at COLS−1 and dir=right, dir flips to left and this step moves left. If `row_pos`=0 and dir=left, dir flips to right and this step moves right.
  - If W==COLS, the row never moves.
  - `row_mask` always equals (2^W−1)<<`row_pos`.
  - `drop` → JUDGE. A drop and a step in the same cycle: the step is discarded and the pre-step position is judged.
- JUDGE (one cycle):
  - ov = `row_mask` & effective base.
  - ov≠0: `base_mask`←ov, cur_w←popcount(ov), success flag set.
  - ov=0: `base_mask`←all ones, cur_w←COLS, fail flag set.
- REPORT (one cycle):
  - Exactly one of `next_signal`/`fail` is high.
  - `row_mask` holds the judged row.
  - Then IDLE.
- `start` outside IDLE is ignored. `drop` outside MOVE is ignored.
- Width arithmetic is unsigned. popcount returns 0..COLS in POSW bits. `num_blocks`=0 is treated as 1.

## Timing
- Reset values:
  - state=IDLE
  - `row_mask`=0, `row_pos`=0
  - `base_mask`=all ones, cur_w=COLS
  - `next_signal`=0, `fail`=0, `busy`=0
  - fc=0, dir=right
- Reset mid-operation aborts immediately with no result pulse.
- `start` at edge N → `busy`=1 and `row_mask` valid at N+1.
- `drop` at edge N → JUDGE at N+1 → `next_signal`/`fail` high for exactly cycle N+2 → IDLE at N+3.
- `base_mask` updates at the same edge that `next_signal`/`fail` rises.
- Step latency: the position changes on the edge that samples the qualifying `frame_tick`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `STACK_TRIM_EN` defined:
  - Overhanging blocks are trimmed: `base_mask`←ov and cur_w←popcount(ov), as above.
- Not defined:
  - Any nonzero overlap is a success with no trimming.
  - `base_mask`←`row_mask` and cur_w is unchanged.
  - The miss (ov=0) behaviour is identical in both builds.

## Test plan
- Reset then `start`, with `curr_level`=1, `num_blocks`=3, `speed_count`=2 → `row_mask`=0x007; after 2 ticks `row_pos`=1 and `row_mask`=0x00E.
- Bounce, COLS=10, W=3 → `row_pos` runs 0..7, then 6 on the next step, and returns to 0, then 1.
- Level 1 drop at `row_pos`=4, W=3 → `next_signal` one cycle at drop+2, `base_mask`=0x070.
- With `STACK_TRIM_EN`, level 2, W=3, base 0x070, drop at `row_pos`=5 → `next_signal`, `base_mask`=0x060, next row width 2.
- Complete miss at level 2, base 0x070, row 0x007 → `fail` pulse, `base_mask`=0x3FF.
- Drop and step in the same cycle → the pre-step position is judged; `resetn` low during MOVE → all outputs reset and no pulse appears.

Source files
------------

// File: rtl/stack_row_engine.sv
// Moving-row engine: sweeps the active row, latches it on drop, judges overlap.
// Optional build macro STACK_TRIM_EN trims overhanging blocks on a partial hit.
module stack_row_engine #(
    parameter int COLS = 10,
    parameter int POSW = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            frame_tick,
    input  logic            start,
    input  logic            drop,
    input  logic [10:0]     speed_count,
    input  logic [3:0]      num_blocks,
    input  logic [5:0]      curr_level,
    output logic [COLS-1:0] row_mask,
    output logic [POSW-1:0] row_pos,
    output logic [COLS-1:0] base_mask,
    output logic            next_signal,
    output logic            fail,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        JUDGE  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [POSW-1:0] COLS_W = POSW'(COLS);
    localparam logic [POSW:0]   COLS_E = (POSW+1)'(COLS);

    state_t          state_q;
    logic [COLS-1:0] row_mask_q;
    logic [POSW-1:0] row_pos_q;
    logic [COLS-1:0] base_mask_q;
    logic [POSW-1:0] cur_w_q;
    logic [POSW-1:0] w_q;
    logic [10:0]     fc_q;
    logic            dir_q;
    logic            lv1_q;
    logic            next_q;
    logic            fail_q;
    logic            busy_q;

    logic [POSW-1:0] w_d;
    logic [POSW-1:0] pos_d;
    logic            dir_d;
    logic [10:0]     spd_m1;
    logic [COLS-1:0] ov;

    // (2^w - 1) << p, kept in COLS bits
    function automatic logic [COLS-1:0] mk_mask(
        input logic [POSW-1:0] w,
        input logic [POSW-1:0] p
    );
        logic [COLS:0] m;
        m = (COLS+1)'(1) << w;
        m = m - (COLS+1)'(1);
        return m[COLS-1:0] << p;
    endfunction

    function automatic logic [POSW-1:0] popcnt(input logic [COLS-1:0] v);
        logic [POSW-1:0] c;
        c = '0;
        for (int i = 0; i < COLS; i++) c = c + POSW'(v[i]);
        return c;
    endfunction

    // Row width for a new start: min(num_blocks, cur_w, COLS), at least 1
    always_comb begin
        logic [7:0] nb8;
        logic [7:0] cw8;
        logic [7:0] w8;
        nb8 = (num_blocks == 4'd0) ? 8'd1 : 8'(num_blocks);
        cw8 = (curr_level == 6'd1) ? 8'(COLS) : 8'(cur_w_q);
        w8  = (nb8 < cw8) ? nb8 : cw8;
        if (w8 > 8'(COLS)) w8 = 8'(COLS);
        if (w8 == 8'd0) w8 = 8'd1;
        w_d = POSW'(w8);
    end

    // Next column and direction for one step, including wall bounce
    always_comb begin
        logic [POSW:0] edge_r;
        pos_d  = row_pos_q;
        dir_d  = dir_q;
        edge_r = {1'b0, row_pos_q} + {1'b0, w_q};
        if (w_q != COLS_W) begin
            if (!dir_q) begin
                if (edge_r == COLS_E) begin
                    dir_d = 1'b1;
                    pos_d = row_pos_q - 1'b1;
                end else begin
                    pos_d = row_pos_q + 1'b1;
                end
            end else begin
                if (row_pos_q == '0) begin
                    dir_d = 1'b0;
                    pos_d = row_pos_q + 1'b1;
                end else begin
                    pos_d = row_pos_q - 1'b1;
                end
            end
        end
    end

    // Frame-count terminal value and overlap with the effective base row
    always_comb begin
        spd_m1 = (speed_count == 11'd0) ? 11'd0 : speed_count - 11'd1;
        ov     = row_mask_q & (lv1_q ? {COLS{1'b1}} : base_mask_q);
    end

    // Main FSM with all outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            row_mask_q  <= '0;
            row_pos_q   <= '0;
            base_mask_q <= '1;
            cur_w_q     <= COLS_W;
            w_q         <= COLS_W;
            fc_q        <= '0;
            dir_q       <= 1'b0;
            lv1_q       <= 1'b0;
            next_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            next_q <= 1'b0;
            fail_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        w_q        <= w_d;
                        row_pos_q  <= '0;
                        row_mask_q <= mk_mask(w_d, '0);
                        dir_q      <= 1'b0;
                        fc_q       <= '0;
                        lv1_q      <= (curr_level == 6'd1);
                        busy_q     <= 1'b1;
                        state_q    <= MOVE;
                    end
                end
                MOVE: begin
                    if (drop) begin
                        state_q <= JUDGE;
                    end else if (frame_tick) begin
                        if (fc_q == spd_m1) begin
                            fc_q       <= '0;
                            row_pos_q  <= pos_d;
                            dir_q      <= dir_d;
                            row_mask_q <= mk_mask(w_q, pos_d);
                        end else begin
                            fc_q <= fc_q + 11'd1;
                        end
                    end
                end
                JUDGE: begin
                    busy_q  <= 1'b0;
                    state_q <= REPORT;
                    if (ov != '0) begin
                        next_q <= 1'b1;
`ifdef STACK_TRIM_EN
                        base_mask_q <= ov;
                        cur_w_q     <= popcnt(ov);
`else
                        base_mask_q <= row_mask_q;
`endif
                    end else begin
                        fail_q      <= 1'b1;
                        base_mask_q <= '1;
                        cur_w_q     <= COLS_W;
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_mask    = row_mask_q;
    assign row_pos     = row_pos_q;
    assign base_mask   = base_mask_q;
    assign next_signal = next_q;
    assign fail        = fail_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_stack_row_engine.sv
// Bench for stack_row_engine: directed sweeps plus a result scoreboard.
// Expectations follow STACK_TRIM_EN when the bench is built with it.
module tb_stack_row_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_tick;
    logic        start;
    logic        drop;
    logic [10:0] speed_count;
    logic [3:0]  num_blocks;
    logic [5:0]  curr_level;
    logic [9:0]  row_mask;
    logic [3:0]  row_pos;
    logic [9:0]  base_mask;
    logic        next_signal;
    logic        fail;
    logic        busy;

    typedef struct {
        logic       nx;
        logic       fl;
        logic [9:0] base;
    } res_t;

    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    stack_row_engine #(.COLS(10), .POSW(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .start       (start),
        .drop        (drop),
        .speed_count (speed_count),
        .num_blocks  (num_blocks),
        .curr_level  (curr_level),
        .row_mask    (row_mask),
        .row_pos     (row_pos),
        .base_mask   (base_mask),
        .next_signal (next_signal),
        .fail        (fail),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic go(input logic [5:0] lvl, input logic [3:0] nb,
                      input logic [10:0] spd);
        curr_level  = lvl;
        num_blocks  = nb;
        speed_count = spd;
        start       = 1'b1;
        cyc();
        start       = 1'b0;
    endtask

    // Drop (optionally with a tick), then pop and compare the result pulse
    task automatic drop_row(input logic nx, input logic [9:0] base,
                            input logic with_tick);
        res_t e;
        res_t r;
        int   n;
        e.nx = nx;
        e.fl = ~nx;
        e.base = base;
        sb_q.push_back(e);
        drop = 1'b1;
        frame_tick = with_tick;
        cyc();
        drop = 1'b0;
        frame_tick = 1'b0;
        chk("judge_quiet", {30'd0, next_signal, fail}, 32'd0);
        n = 0;
        while (!(next_signal || fail) && n < 6) begin
            cyc();
            n++;
        end
        r = sb_q.pop_front();
        if (!(next_signal || fail)) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            chk("lat", n, 1);
            chk("next", next_signal, r.nx);
            chk("fail", fail, r.fl);
            chk("base", base_mask, r.base);
            chk("busy_rep", busy, 0);
            cyc();
            chk("pulse1", {30'd0, next_signal, fail}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[18] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4};
        int seen;
        logic [9:0] m;
        resetn = 1'b0;
        frame_tick = 1'b0;
        start = 1'b0;
        drop = 1'b0;
        speed_count = 11'd2;
        num_blocks = 4'd3;
        curr_level = 6'd1;
        repeat (2) cyc();
        chk("rst_mask", row_mask, 0);
        chk("rst_pos", row_pos, 0);
        chk("rst_base", base_mask, 10'h3FF);
        chk("rst_out", {29'd0, next_signal, fail, busy}, 0);
        resetn = 1'b1;
        cyc();

        // Level 1, W=3, speed 2: sweep with bounce, drop at column 4
        go(6'd1, 4'd3, 11'd2);
        chk("busy", busy, 1);
        chk("mask0", row_mask, 10'h007);
        foreach (seq[i]) begin
            tick();
            chk("hold", row_pos, (i == 0) ? 0 : seq[i-1]);
            tick();
            m = 10'h007 << seq[i];
            chk("pos", row_pos, seq[i]);
            chk("mask", row_mask, m);
        end
        drop_row(1'b1, 10'h070, 1'b0);
        chk("rep_mask", row_mask, 10'h070);

        // Level 2 partial hit at column 5 against base 0x070
        go(6'd2, 4'd3, 11'd1);
        repeat (5) tick();
        chk("pos5", row_pos, 5);
`ifdef STACK_TRIM_EN
        drop_row(1'b1, 10'h060, 1'b0);
        go(6'd3, 4'd3, 11'd1);
        chk("trim_w", row_mask, 10'h003);
`else
        drop_row(1'b1, 10'h0E0, 1'b0);
        go(6'd3, 4'd3, 11'd1);
        chk("keep_w", row_mask, 10'h007);
`endif
        drop_row(1'b0, 10'h3FF, 1'b0);

        // Complete miss: base 0x070, row 0x007
        go(6'd1, 4'd3, 11'd1);
        repeat (4) tick();
        drop_row(1'b1, 10'h070, 1'b0);
        go(6'd2, 4'd3, 11'd1);
        chk("miss_row", row_mask, 10'h007);
        drop_row(1'b0, 10'h3FF, 1'b0);

        // Full-width row never moves
        go(6'd2, 4'd15, 11'd1);
        chk("full", row_mask, 10'h3FF);
        repeat (3) tick();
        chk("full_pos", row_pos, 0);
        drop_row(1'b1, 10'h3FF, 1'b0);

        // Drop and step together; start inside MOVE ignored
        go(6'd1, 4'd2, 11'd1);
        repeat (3) tick();
        chk("pos3", row_pos, 3);
        go(6'd1, 4'd5, 11'd1);
        chk("ign_start", row_mask, 10'h018);
        drop_row(1'b1, 10'h018, 1'b1);
        chk("rep_hold", row_mask, 10'h018);

        // num_blocks 0 -> 1, speed 0 -> step each tick, then reset mid-flight
        go(6'd1, 4'd0, 11'd0);
        chk("w1", row_mask, 10'h001);
        tick();
        chk("spd0", row_pos, 1);
        tick();
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        resetn = 1'b0;
        #1;
        chk("ar_mask", row_mask, 0);
        chk("ar_pos", row_pos, 0);
        chk("ar_base", base_mask, 10'h3FF);
        chk("ar_busy", busy, 0);
        seen = 0;
        repeat (2) begin
            cyc();
            if (next_signal || fail) seen++;
        end
        resetn = 1'b1;
        repeat (3) begin
            cyc();
            if (next_signal || fail) seen++;
        end
        chk("no_pulse", seen, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
